// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1-style UART receiver with a valid/ready byte output and
// sticky framing-error / overrun status flags.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | line idle, waiting for a synchronized low (start edge)
// START     | half-bit wait, then confirm the start bit is still low
// DATA      | one sample per bit time, DATA_BITS samples, LSB first
// STOP      | one bit time, then sample the stop bit
// WAIT_HIGH | stop bit was low; hold off until the line returns high
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr,
  output logic       busy
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  // CLKS_PER_BIT-1 is the largest value the tick counter ever holds.
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_BIT  = 4'(DATA_BITS - 1);

  logic                 sync1_q, sync2_q;
  logic                 rs;
  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 tick;
  logic                 stop_good;
  logic                 stop_bad;
  logic                 ovr_set;

  assign rs   = sync2_q;
  assign tick = (cnt_q == '0);

  // Two-flop synchronizer on the asynchronous serial line; resets to idle-high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
    end
  end

  // Frame sequencing: state, bit-time down-counter, bit index and shift register.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rs) begin
          state_d = ST_START;
          cnt_d   = HALF_LOAD;
        end
      end
      ST_START: begin
        if (tick) begin
          if (!rs) begin
            state_d   = ST_DATA;
            cnt_d     = FULL_LOAD;
            bit_idx_d = '0;
          end else begin
            // Low pulse shorter than half a bit: treat as noise.
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d   = {rs, shift_q[DATA_BITS-1:1]};
          cnt_d     = FULL_LOAD;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == LAST_BIT) begin
            state_d = ST_STOP;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (rs) begin
            stop_good = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = ST_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WAIT_HIGH: begin
        // A held-low line (break) must not be mistaken for a new start bit.
        if (rs) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output holding register, valid/ready handshake and sticky error flags.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_set = 1'b0;
    if (stop_good) begin
      if (!valid_q || rx_ready) begin
        data_d                 = '0;
        data_d[DATA_BITS-1:0]  = shift_q;
        valid_d                = 1'b1;
      end else begin
        // Previous byte still held: keep it, drop the new one.
        ovr_set = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
    // A new error on the same edge as err_clr takes priority.
    ferr_d = stop_bad | (ferr_q & ~err_clr);
    ovr_d  = ovr_set  | (ovr_q  & ~err_clr);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- UART receiver for the tiny1 SoC serial link: samples RXD, deframes 8N1 characters and presents bytes on a valid/ready interface.
- Serves as the far end of the SoC TXD line in bench loopback, and as the SoC-side input behind RXD.
- Provides sticky framing-error and overrun flags for the CPU status register.

Parameters:
CLKS_PER_BIT, 104, clock cycles per bit time (12 MHz / 115200); legal range >= 4
DATA_BITS, 8, data bits per character, LSB first; legal range 5..8

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  asynchronous active-low reset
rxd  input  1  serial line, idle high, asynchronous to clk
rx_data  output  8  received byte; unused MSBs are 0 when DATA_BITS < 8
rx_valid  output  1  rx_data holds an unconsumed byte
rx_ready  input  1  consumer accepts rx_data on a posedge where rx_valid=1
frame_err  output  1  sticky: stop bit sampled low
overrun  output  1  sticky: a byte completed while the previous byte was still held
err_clr  input  1  clears frame_err and overrun on the next posedge
busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, bit counter=0, tick counter=0, synchronizer flops=1.
- Reset values of outputs: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
- A mid-frame reset discards the partial character; no flag is set.
- Input path: rxd goes through a 2-flop synchronizer. All decisions use the synchronized value rs, which lags rxd by 2 cycles.
- IDLE: on rs=0, go to START and load tick counter with CLKS_PER_BIT/2-1 (integer division).
- START: when the tick counter reaches 0, sample rs.
  - rs=0: go to DATA, reload counter with CLKS_PER_BIT-1, bit index=0.
  - rs=1: glitch; return to IDLE with no flag and no output.
- DATA: at each counter expiry, shift rs into the shift register MSB-first-in so the result is LSB-first, reload the counter and increment the bit index. After DATA_BITS samples, go to STOP.
- STOP: at counter expiry, sample rs.
  - rs=1, good frame: deliver the byte (see delivery rules), go to IDLE.
  - rs=0: set frame_err, drop the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until rs=1, then go to IDLE. This prevents a break condition from retriggering a start.
- Delivery on a good frame:
  - If rx_valid=0, or rx_valid=1 with rx_ready=1 on the same edge: load rx_data and set rx_valid=1.
  - If rx_valid=1 and rx_ready=0: keep the old rx_data, drop the new byte, set overrun.
- Consume: on a posedge with rx_valid=1 and rx_ready=1 and no delivery in that cycle, clear rx_valid. rx_ready while rx_valid=0 has no effect.
- rx_data is stable while rx_valid=1 and only changes on a delivery.
- err_clr:
  - Clears both flags on the next posedge.
  - If err_clr coincides with a new error event, the error wins and the flag stays 1.
- Latency: rx_valid rises exactly 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT cycles (±1) after the rxd falling edge.
- A start bit is accepted on the cycle after returning to IDLE (back-to-back frames with no idle gap).
- busy=1 in START, DATA, STOP and WAIT_HIGH.

Test Plan:
- CLKS_PER_BIT=16, send 0x55 8N1, rx_ready=0 → rx_valid rises 2+8+144 (±1) cycles after the start edge, rx_data=0x55, flags 0. Pulse rx_ready → rx_valid=0 on the next cycle.
- Send 0xA3 then 0x3C back-to-back with no idle gap, rx_ready held 1 → two single-cycle rx_valid pulses carrying 0xA3 then 0x3C; overrun=0.
- Send 0x12 and leave it unconsumed, then send 0x34 → rx_data stays 0x12, overrun=1. Pulse err_clr → overrun=0, rx_data still 0x12.
- Send 0x7E with the stop bit driven low, hold rxd low for 40 bit times, then release high and send 0x81 → frame_err=1, no delivery of 0x7E, busy high throughout the low period, then rx_data=0x81.
- 5-cycle low glitch on idle rxd → returns to IDLE, no rx_valid, no flags. Also assert rst=0 mid-DATA of 0xFF → all outputs 0 immediately; the next clean 0x0F frame is received correctly.
- Delivery of 0x99 on the same edge as rx_ready=1 consuming 0x11 → rx_data=0x99, rx_valid stays 1, overrun=0.
